// File: rtl/seg_digit_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment digit scanner.
// Optional leading-zero blanking is enabled with SEG_LEADING_ZERO_BLANK_EN.
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 16;

    // Active-low anode pattern with only bit idx pulled low.
    function automatic logic [MAX_DIGITS-1:0] onehot_low(input logic [3:0] idx);
        logic [MAX_DIGITS-1:0] pat;
        pat      = {MAX_DIGITS{1'b1}};
        pat[idx] = 1'b0;
        return pat;
    endfunction

endpackage

// File: rtl/seg_digit_scan_if.sv
// Write port of the digit scanner: one-cycle strobe plus packed digit word.
interface seg_digit_scan_if
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) ();

    logic                          wr_en;
    logic [DIGIT_W*NUM_DIGITS-1:0] wr_data;

    modport master (output wr_en, output wr_data);
    modport slave  (input  wr_en, input  wr_data);

endinterface

// File: rtl/seg_digit_scan_tick_gen.sv
// Slot timer: counts clocks within one digit slot and flags the wrap and
// the leading dead-time window.
module seg_tick_gen #(
    parameter  int PRESCALE = 1000,
    parameter  int DEADTIME = 2,
    localparam int CNT_W    = $clog2(PRESCALE)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt_o,
    output logic             slot_wrap_o,
    output logic             in_dead_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count and slot flags decoded from the current count.
    always_comb begin
        slot_wrap_o = (cnt_q == CNT_W'(PRESCALE - 1));
        in_dead_o   = (cnt_q < CNT_W'(DEADTIME));
        if (slot_wrap_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Slot counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seg_digit_scan.sv
// Time-multiplexed 7-segment digit scanner with frame-aligned double buffer.
// Define SEG_LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg_digit_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000,
    parameter int DEADTIME   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    seg_digit_scan_if.slave               wr_bus,
    output logic [DIGIT_W-1:0]            D,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_strb
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = $clog2(PRESCALE);
    localparam int WORD_W = DIGIT_W * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt_s;
    logic                  slot_wrap_s;
    logic                  in_dead_s;
    logic                  frame_end_s;
    logic [DIGIT_W-1:0]    cur_digit_s;
    logic [NUM_DIGITS-1:0] drive_pat_s;

    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [WORD_W-1:0]     disp_q,     disp_d;
    logic [WORD_W-1:0]     pend_q,     pend_d;
    logic                  pend_vld_q, pend_vld_d;

    scan_state_t           state_q;
    logic [DIGIT_W-1:0]    d_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  strb_q;

    seg_tick_gen #(
        .PRESCALE (PRESCALE),
        .DEADTIME (DEADTIME)
    ) u_tick (
        .clk         (clk),
        .rst         (rst),
        .cnt_o       (cnt_s),
        .slot_wrap_o (slot_wrap_s),
        .in_dead_o   (in_dead_s)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic                  zero_run_s;

    // Leading-zero mask of the word that becomes visible at the boundary.
    always_comb begin
        blank_d    = '0;
        zero_run_s = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run_s = zero_run_s && (disp_d[i*DIGIT_W +: DIGIT_W] == 4'h0);
            blank_d[i] = zero_run_s;
        end
    end

    // Blank flags are refreshed only together with the display register.
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
        end else if (frame_end_s) begin
            blank_q <= blank_d;
        end else begin
            blank_q <= blank_q;
        end
    end
`endif

    // Digit index stepping, double-buffer transfer and anode pattern.
    always_comb begin
        frame_end_s = slot_wrap_s && (idx_q == IDX_W'(NUM_DIGITS - 1));

        if (!slot_wrap_s) begin
            idx_d = idx_q;
        end else if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d = '0;
        end else begin
            idx_d = idx_q + IDX_W'(1);
        end

        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        // Transfer uses the old pending word, so a same-cycle write waits a frame.
        if (frame_end_s && pend_vld_q) begin
            disp_d     = pend_q;
            pend_vld_d = 1'b0;
        end else begin
            disp_d     = disp_q;
        end
        if (wr_bus.wr_en) begin
            pend_d     = wr_bus.wr_data;
            pend_vld_d = 1'b1;
        end else begin
            pend_d     = pend_q;
        end

        cur_digit_s = disp_q[idx_q*DIGIT_W +: DIGIT_W];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (blank_q[idx_q]) begin
            drive_pat_s = '1;
        end else begin
            drive_pat_s = NUM_DIGITS'(onehot_low(4'(idx_q)));
        end
`else
        drive_pat_s = NUM_DIGITS'(onehot_low(4'(idx_q)));
`endif
    end

    // Digit index and double-buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            disp_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    // Blank/drive FSM with registered digit, anode and strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
            d_q     <= 4'h0;
            an_q    <= '1;
            strb_q  <= 1'b0;
        end else begin
            d_q    <= cur_digit_s;
            strb_q <= frame_end_s;
            case (state_q)
                BLANK: begin
                    if (cnt_s == CNT_W'(DEADTIME)) begin
                        state_q <= DRIVE;
                        an_q    <= drive_pat_s;
                    end else begin
                        state_q <= BLANK;
                        an_q    <= '1;
                    end
                end
                DRIVE: begin
                    if (in_dead_s) begin
                        state_q <= BLANK;
                        an_q    <= '1;
                    end else begin
                        state_q <= DRIVE;
                        an_q    <= drive_pat_s;
                    end
                end
                default: begin
                    state_q <= BLANK;
                    an_q    <= '1;
                end
            endcase
        end
    end

    assign D          = d_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_strb = strb_q;

endmodule

// File: tb/tb_seg_digit_scan.sv
// Directed bench for seg_digit_scan (4 digits, 8 clocks/slot, 2 dead clocks)
// with a write-history model checked every cycle plus literal spot checks.
module tb_seg_digit_scan;

    localparam int N     = 4;
    localparam int P     = 8;
    localparam int DT    = 2;
    localparam int FRAME = N * P;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] D;
    logic [3:0] an;
    logic [1:0] digit_idx;
    logic       frame_strb;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int first_strb;

    seg_digit_scan_if #(.NUM_DIGITS(N)) wr_bus ();

    seg_digit_scan #(
        .NUM_DIGITS (N),
        .PRESCALE   (P),
        .DEADTIME   (DT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_bus     (wr_bus),
        .D          (D),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_strb (frame_strb)
    );

    always #5 clk = ~clk;

    // Model: cycle k counts edges since the last reset edge; a write seen in
    // cycle s becomes visible after the first boundary cycle strictly after s.
    int          m_k     = 0;
    bit          m_valid = 1'b0;
    int          m_ws[$];
    logic [15:0] m_wd[$];

    function automatic logic [15:0] disp_at(input int j);
        logic [15:0] w;
        w = 16'h0000;
        for (int i = 0; i < m_ws.size(); i++) begin
            if (((m_ws[i] + 1) / FRAME) * FRAME + (FRAME - 1) < j) w = m_wd[i];
        end
        return w;
    endfunction

    always @(negedge clk) begin : compare
        logic [3:0]  e_d, e_an;
        logic [1:0]  e_idx;
        logic        e_strb;
        logic [15:0] word;
        int          j, pslot;
        if (m_valid) begin
            e_idx  = 2'((m_k / P) % N);
            e_d    = 4'h0;
            e_an   = 4'hF;
            e_strb = 1'b0;
            if (m_k > 0) begin
                j      = m_k - 1;
                pslot  = (j / P) % N;
                word   = disp_at(j);
                e_d    = 4'((word >> (4 * pslot)) & 16'h000F);
                e_strb = ((j % FRAME) == FRAME - 1);
                if ((j % P) >= DT) begin
                    e_an = ~(4'b0001 << pslot);
`ifdef SEG_LEADING_ZERO_BLANK_EN
                    if (pslot != 0 && (word >> (4 * pslot)) == 16'h0000) e_an = 4'hF;
`endif
                end
            end
            checks++;
            if (D !== e_d || an !== e_an || digit_idx !== e_idx || frame_strb !== e_strb
                || $countones(~an) > 1) begin
                $display("FAIL model k=%0d: D=%h/%h an=%b/%b idx=%0d/%0d strb=%b/%b (got/want)",
                         m_k, D, e_d, an, e_an, digit_idx, e_idx, frame_strb, e_strb);
            end else begin
                passes++;
            end
        end
        if (rst) begin
            m_valid = 1'b1;
            m_k     = 0;
            m_ws.delete();
            m_wd.delete();
        end else if (m_valid) begin
            if (wr_bus.wr_en) begin
                m_ws.push_back(m_k);
                m_wd.push_back(wr_bus.wr_data);
            end
            m_k++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s (cyc %0d): got %h expected %h", name, cyc, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic write_word(input logic [15:0] w);
        wr_bus.wr_en   = 1'b1;
        wr_bus.wr_data = w;
    endtask

    initial begin
        rst            = 1'b1;
        wr_bus.wr_en   = 1'b0;
        wr_bus.wr_data = 16'h0000;

        // Reset held for three clocks.
        repeat (3) begin
            tick();
            chk("rst_an",   32'(an),         32'hF);
            chk("rst_D",    32'(D),          32'h0);
            chk("rst_strb", 32'(frame_strb), 32'h0);
        end
        rst = 1'b0;
        cyc = 0;

        // First frame, mid-frame write of 1234, then its display frame.
        first_strb = -1;
        for (int c = 0; c < 64; c++) begin
            tick();
            case (cyc)
                2:  chk("dead_an_c2",  32'(an), 32'hF);
                3:  chk("drive_an_c3", 32'(an), 32'hE);
                5:  write_word(16'h1234);
                6:  wr_bus.wr_en = 1'b0;
                8:  chk("drive_an_c8", 32'(an), 32'hE);
                9:  chk("dead_an_c9",  32'(an), 32'hF);
                35: begin chk("s0_D", 32'(D), 32'h4); chk("s0_an", 32'(an), 32'hE); end
                43: begin chk("s1_D", 32'(D), 32'h3); chk("s1_an", 32'(an), 32'hD); end
                51: chk("s2_D", 32'(D), 32'h2);
                59: begin chk("s3_D", 32'(D), 32'h1); chk("s3_an", 32'(an), 32'h7); end
                default: ;
            endcase
            if (frame_strb === 1'b1 && first_strb < 0) first_strb = cyc;
        end
        chk("first_strb", 32'(first_strb), 32'd32);

        // Boundary collision: AAAA mid-frame, 5555 on boundary cycle 95.
        while (cyc < 180) begin
            tick();
            case (cyc)
                70:  write_word(16'hAAAA);
                71:  wr_bus.wr_en = 1'b0;
                95:  write_word(16'h5555);
                96:  wr_bus.wr_en = 1'b0;
                99:  chk("coll_A_s0", 32'(D), 32'hA);
                123: begin chk("coll_A_s3", 32'(D), 32'hA); chk("coll_an_s3", 32'(an), 32'h7); end
                131: chk("coll_5_s0", 32'(D), 32'h5);
                140: chk("pend_clear", 32'(dut.pend_vld_q), 32'h0);
                155: chk("coll_5_s3", 32'(D), 32'h5);
                172: write_word(16'h9876);
                173: wr_bus.wr_en = 1'b0;
                178: chk("pend_set", 32'(dut.pend_vld_q), 32'h1);
                default: ;
            endcase
        end

        // Cycle 180 is cnt=4 of slot 2: reset here discards the pending 9876.
        rst = 1'b1;
        tick();
        chk("mid_rst_an",  32'(an),        32'hF);
        chk("mid_rst_idx", 32'(digit_idx), 32'h0);
        chk("mid_rst_D",   32'(D),         32'h0);
        rst = 1'b0;
        cyc = 0;
        while (cyc < 70) begin
            tick();
            case (cyc)
                35: chk("discard_D35", 32'(D), 32'h0);
                40: begin chk("discard_D40", 32'(D), 32'h0); chk("discard_an40", 32'(an), 32'hE); end
                default: ;
            endcase
        end

`ifdef SEG_LEADING_ZERO_BLANK_EN
        // Leading-zero blanking: 0042 then 0000.
        while (cyc < 190) begin
            tick();
            case (cyc)
                72:  write_word(16'h0042);
                73:  wr_bus.wr_en = 1'b0;
                99:  begin chk("lz_s0_D", 32'(D), 32'h2); chk("lz_s0_an", 32'(an), 32'hE); end
                107: begin chk("lz_s1_D", 32'(D), 32'h4); chk("lz_s1_an", 32'(an), 32'hD); end
                115: chk("lz_s2_an", 32'(an), 32'hF);
                123: chk("lz_s3_an", 32'(an), 32'hF);
                130: write_word(16'h0000);
                131: wr_bus.wr_en = 1'b0;
                163: begin chk("lz0_s0_D", 32'(D), 32'h0); chk("lz0_s0_an", 32'(an), 32'hE); end
                171: chk("lz0_s1_an", 32'(an), 32'hF);
                179: chk("lz0_s2_an", 32'(an), 32'hF);
                default: ;
            endcase
        end
`endif

        tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seg_digit_scan.md
Name: seg_digit_scan

Overview:
Time-multiplexed digit scanner for the multi-digit 7-segment display. It accepts a packed BCD/hex word and cycles through the digits, one per time slot. Each slot it presents the selected 4-bit digit code on D, which drives the per-segment decoders (segA..segG), plus an active-low one-hot anode select. New words are double-buffered and applied only at frame boundaries, so the display never shows a torn word.

Parameters:
NUM_DIGITS, 4, number of digits scanned; anode width.
PRESCALE, 1000, clocks per digit slot; must be >= DEADTIME+2.
DEADTIME, 2, clocks at the start of each slot with all anodes off (anti-ghosting); must be >= 1.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
wr_en  input  1  one-cycle strobe; captures wr_data into the pending buffer.
wr_data  input  4*NUM_DIGITS  packed digits; wr_data[3:0] is digit 0, the rightmost, on an[0].
D  output  4  digit code to the segment decoders; registered.
an  output  NUM_DIGITS  active-low anode enables; at most one bit low; registered.
digit_idx  output  $clog2(NUM_DIGITS)  index of the slot currently being scanned.
frame_strb  output  1  one-cycle pulse at the frame boundary, on the cycle the display register updates.

Behaviour:
- Reset (sync, rst=1 at an edge) produces the following values:
  - slot counter cnt=0, digit_idx=0, state=BLANK.
  - display register disp=0, pending register=0, pend_vld=0.
  - D=4'h0, an=all 1s, frame_strb=0.
  - Reset asserted mid-slot or mid-frame aborts immediately; any pending write is discarded.
- Slot counter:
  - cnt counts 0..PRESCALE-1 and wraps to 0.
  - On wrap, digit_idx increments; it wraps from NUM_DIGITS-1 to 0.
- State machine, 2 states, evaluated on cnt:
  - BLANK while cnt < DEADTIME: an=all 1s; D still updates to the current digit.
  - DRIVE while cnt >= DEADTIME: an[digit_idx]=0, all other anode bits 1.
  - Transition BLANK->DRIVE at cnt==DEADTIME; DRIVE->BLANK at the slot wrap.
- Output latency: D and an are registered, so they lag cnt/digit_idx by exactly 1 clock. In cycle-level terms, an goes low on the clock after cnt becomes DEADTIME.
- Write path:
  - wr_en=1 loads pending<=wr_data and sets pend_vld=1.
  - Back-to-back writes: the last one wins.
  - No backpressure; wr_en is accepted in every cycle.
- Frame boundary is the cycle where cnt==PRESCALE-1 and digit_idx==NUM_DIGITS-1. On it:
  - frame_strb pulses for one cycle.
  - If pend_vld, disp<=pending and pend_vld is cleared.
- Simultaneous wr_en at the frame boundary:
  - The old pending value transfers to disp.
  - The new wr_data goes into pending with pend_vld=1 and is applied at the next boundary.
  - If pend_vld was 0 at that boundary, disp is unchanged and the new word waits a full frame.
- Frame length is exactly NUM_DIGITS*PRESCALE clocks; frame_strb period equals that.
- D values 4'hA..4'hF are passed through unmodified; the decoders define their glyphs.

Optional Feature:
Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: in DRIVE, a digit slot keeps an=all 1s when that digit and every more-significant digit of disp are 4'h0. Digit 0 is never blanked, so value 0 still shows a single "0". Blank flags are computed from disp once per frame boundary, not per cycle.
- Undefined: every digit is driven in DRIVE, and leading zeros are displayed.

Decomposition:
- Package seg_pkg holds:
  - typedef enum logic {BLANK, DRIVE} scan_state_t.
  - localparam DIGIT_W=4.
  - Helper function onehot_low(idx) returning the active-low anode pattern.
- Sub-module seg_tick_gen: parameterised PRESCALE/DEADTIME counter with outputs cnt, slot_wrap and in_dead.
- Top level holds the digit index, the double buffer, the FSM and the output registers.

Test Plan:
All scenarios use NUM_DIGITS=4, PRESCALE=8, DEADTIME=2.
1. Reset: hold rst 3 clocks, then release. Required response:
   - an=4'b1111, D=0, frame_strb=0 throughout reset.
   - First frame_strb exactly 32 clocks after release.
   - With disp=0 and the feature off, an=1110 from clock 3 to clock 8 of slot 0.
2. Write mid-frame: pulse wr_en with wr_data=16'h1234 at clock 5 after reset. Required response:
   - The first frame still shows D=0.
   - After frame_strb, slot 0 gives D=4, an=1110; slot 1 gives D=3, an=1101; slot 2 gives D=2; slot 3 gives D=1, an=0111.
3. Deadtime: for any slot, an=1111 for exactly 2 clocks after each digit_idx change (+1 latency), then a single low bit for 6 clocks. Never two bits low; never a low bit across an index change.
4. Boundary collision:
   - Write 16'hAAAA mid-frame.
   - Then write 16'h5555 exactly on the boundary cycle.
   - Required response: the next frame shows A in all slots; the frame after shows 5; pend_vld is clear afterward.
5. Reset mid-operation: assert rst at cnt=4 of slot 2 with pend_vld=1. Required response:
   - Next clock: an=1111, digit_idx=0, D=0.
   - The pending value is never displayed.
6. Feature (macro defined): load 16'h0042. Required response:
   - Slots 2 and 3 keep an=1111; slot 0 gives D=2, an=1110; slot 1 gives D=4.
   - Then load 16'h0000: only slot 0 is driven, with D=0.
